shared_affine_serial: RTL and testbench

SHARED_AFFINE_SERIAL -- requirements
Module: shared_affine_serial

---
 rtl/midori_ti_pkg.sv | 20 ++
 rtl/affine_nibble.sv | 34 +++
 rtl/shared_affine_serial.sv | 125 ++++++++++++
 tb/tb_shared_affine_serial.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midori_ti_pkg.sv
// Shared definitions for the threshold-implementation Midori datapath.
// Holds the affine-map mode encoding, the affine constants for both maps
// and the state encoding of the serial affine FSM.
package midori_ti_pkg;

  // in_mode encoding: MAP_B is the inverse of MAP_A.
  localparam logic MODE_A = 1'b0;
  localparam logic MODE_B = 1'b1;

  // Affine constants, XORed into share 0 only.
  localparam logic [3:0] CONST_A = 4'h5;
  localparam logic [3:0] CONST_B = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/affine_nibble.sv
// Affine transform of one 4-bit nibble of one share.
// Ports:
//   x         : input nibble (bit 0 = x0)
//   mode      : MODE_A or MODE_B
//   add_const : 1 only on share 0; other shares take the linear part only
//   y         : transformed nibble
module affine_nibble
  import midori_ti_pkg::*;
(
  input  logic [3:0] x,
  input  logic       mode,
  input  logic       add_const,
  output logic [3:0] y
);

  logic [3:0] lin;
  logic [3:0] k;

  always_comb begin
    lin = 4'h0;
    k   = 4'h0;
    if (mode == MODE_A) begin
      // y0=x1, y1=x2, y2=x3, y3=x0^x1
      lin = {x[0] ^ x[1], x[3], x[2], x[1]};
      k   = CONST_A;
    end else begin
      // y0=x0^x3, y1=x0, y2=x1, y3=x2
      lin = {x[2], x[1], x[0], x[0] ^ x[3]};
      k   = CONST_B;
    end
    y = lin ^ (add_const ? k : 4'h0);
  end

endmodule

// File: rtl/shared_affine_serial.sv
// Serial affine layer over a masked (XOR-shared) Midori state.
// Each share is transformed LANES nibbles per cycle; the share registers
// rotate right so transformed nibbles re-enter at the top and, after
// NIBBLES/LANES cycles, every nibble is back in its original position.
// Share paths never mix, so the block keeps the non-completeness property.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high; the producer holds data stable while valid is high and
// ready is low; out_shares is held stable while out_valid is high until
// the transfer completes.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : input state offered
//   in_ready    : block accepts input this cycle
//   in_mode     : MODE_A / MODE_B
//   in_shares   : share s at [s*4*NIBBLES +: 4*NIBBLES]
//   out_valid   : result available
//   out_ready   : consumer takes result
//   out_shares  : transformed shares, same packing
//   dbg_state   : current FSM state
module shared_affine_serial
  import midori_ti_pkg::*;
#(
  parameter int NIBBLES = 16,
  parameter int SHARES  = 3,
  parameter int LANES   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mode,
  input  logic [SHARES*4*NIBBLES-1:0] in_shares,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SHARES*4*NIBBLES-1:0] out_shares,
  output state_t                      dbg_state
);

  localparam int W     = 4 * NIBBLES;
  localparam int STEPS = NIBBLES / LANES;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int KEEP  = NIBBLES - LANES;

  state_t                    state_q, state_d;
  logic   [CW-1:0]           cnt_q;
  logic                      mode_q;
  logic   [SHARES-1:0][W-1:0] sh_q;
  logic   [3:0]              xf [SHARES][LANES];
  logic   [3:0]              nd [SHARES][NIBBLES];
  logic                      accept;

  for (genvar s = 0; s < SHARES; s++) begin : g_share
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      affine_nibble u_aff (
        .x         (sh_q[s][4*l +: 4]),
        .mode      (mode_q),
        .add_const (s == 0),
        .y         (xf[s][l])
      );
    end
    // Rotate right by LANES nibbles; the transformed low nibbles land on top.
    for (genvar n = 0; n < NIBBLES; n++) begin : g_nib
      if (n < KEEP) begin : g_keep
        assign nd[s][n] = sh_q[s][4*(n+LANES) +: 4];
      end else begin : g_new
        assign nd[s][n] = xf[s][n-KEEP];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q == CW'(STEPS - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        // Result consumed: either start the next operation straight away
        // or go idle.
        if (out_ready) state_d = in_valid ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_A;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sh_q   <= in_shares;
        mode_q <= in_mode;
        cnt_q  <= '0;
      end else if (state_q == ST_RUN) begin
        for (int s = 0; s < SHARES; s++) begin
          for (int n = 0; n < NIBBLES; n++) begin
            sh_q[s][4*n +: 4] <= nd[s][n];
          end
        end
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign out_shares = sh_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_shared_affine_serial.sv
// Bench for shared_affine_serial: three instances (LANES 1, 4, 16) share
// one stimulus stream and are each compared with a nibble-level model.
module tb_shared_affine_serial;
  import midori_ti_pkg::*;

  localparam int N  = 16;
  localparam int S  = 3;
  localparam int W  = 64;
  localparam int SW = S * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          in_mode;
  logic [SW-1:0] in_shares;
  logic          out_ready;

  logic          in_ready_w  [3];
  logic          out_valid_w [3];
  logic [SW-1:0] out_shares_w[3];
  state_t        dbg_w       [3];

  int lanes_of[3] = '{1, 4, 16};

  shared_affine_serial #(.NIBBLES(N), .SHARES(S), .LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_mode(in_mode), .in_shares(in_shares), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .out_shares(out_shares_w[0]), .dbg_state(dbg_w[0]));

  shared_affine_serial #(.NIBBLES(N), .SHARES(S), .LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_mode(in_mode), .in_shares(in_shares), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .out_shares(out_shares_w[1]), .dbg_state(dbg_w[1]));

  shared_affine_serial #(.NIBBLES(N), .SHARES(S), .LANES(16)) u_l16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_mode(in_mode), .in_shares(in_shares), .out_valid(out_valid_w[2]),
    .out_ready(out_ready), .out_shares(out_shares_w[2]), .dbg_state(dbg_w[2]));

  // ---------------- scoreboard ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] res_q[3];
  int            lat_q[3];
  state_t        st1_q[3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] lin_ref(input logic [3:0] x, input logic m);
    logic [3:0] t;
    if (m == MODE_A) begin
      t = (x ^ (x >> 1)) & 4'h1;
      return (x >> 1) | (t << 3);
    end
    t = (x ^ (x >> 3)) & 4'h1;
    return ((x << 1) & 4'hE) | t;
  endfunction

  function automatic logic [SW-1:0] model(input logic [SW-1:0] v, input logic m);
    logic [SW-1:0] r;
    logic [3:0]    c;
    c = (m == MODE_A) ? 4'h5 : 4'hB;
    for (int s = 0; s < S; s++)
      for (int n = 0; n < N; n++)
        r[s*W + 4*n +: 4] = lin_ref(v[s*W + 4*n +: 4], m) ^ ((s == 0) ? c : 4'h0);
    return r;
  endfunction

  function automatic logic [63:0] xor_of(input logic [SW-1:0] v);
    return v[63:0] ^ v[127:64] ^ v[191:128];
  endfunction

  function automatic logic [SW-1:0] rand_sh();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_accept(input logic m, input logic [SW-1:0] v);
    @(negedge clk);
    in_valid  = 1'b1;
    in_mode   = m;
    in_shares = v;
    exp_q.push_back(model(v, m));
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("accept_rdy_l%0d", lanes_of[k]), 64'(in_ready_w[k]), 64'd1);
    @(posedge clk);
  endtask

  // Waits after an accept edge for every instance's out_valid; cycle 1 is
  // the first cycle after the accept edge. With garbage set, in_valid stays
  // high with the opposite mode and fresh data during cycles 1..16.
  task automatic collect(input bit garbage, input logic m);
    bit got[3];
    got = '{0, 0, 0};
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!garbage || c >= 17) begin
        in_valid = 1'b0;
      end else begin
        in_valid  = 1'b1;
        in_mode   = ~m;
        in_shares = rand_sh();
      end
      for (int k = 0; k < 3; k++) begin
        if (c == 1) st1_q[k] = dbg_w[k];
        if (!got[k] && out_valid_w[k]) begin
          got[k]   = 1;
          res_q[k] = out_shares_w[k];
          lat_q[k] = c;
        end
      end
      if (got[0] && got[1] && got[2]) break;
    end
    for (int k = 0; k < 3; k++)
      if (!got[k]) begin
        check($sformatf("timeout_l%0d", lanes_of[k]), 64'd0, 64'd1);
        lat_q[k] = -1;
        res_q[k] = '0;
      end
  endtask

  task automatic check_op(input string tag);
    logic [SW-1:0] e;
    e = exp_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < S; s++)
        check($sformatf("%s_l%0d_s%0d", tag, lanes_of[k], s),
              res_q[k][s*W +: W], e[s*W +: W]);
      check($sformatf("%s_lat_l%0d", tag, lanes_of[k]),
            64'(lat_q[k]), 64'(N / lanes_of[k] + 1));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [SW-1:0] v, e;
    logic          m;
    logic [63:0]   m1, m2;
    int            seen;

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_shares = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_in_ready_l%0d", lanes_of[k]), 64'(in_ready_w[k]), 64'd0);
      check($sformatf("rst_state_l%0d", lanes_of[k]), 64'(dbg_w[k]), 64'(ST_IDLE));
      check($sformatf("rst_out_valid_l%0d", lanes_of[k]), 64'(out_valid_w[k]), 64'd0);
      check($sformatf("rst_out_l%0d", lanes_of[k]), xor_of(out_shares_w[k]) | out_shares_w[k][63:0], 64'd0);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("idle_in_ready_l%0d", lanes_of[k]), 64'(in_ready_w[k]), 64'd1);

    // All-zero shares, MAP_A.
    do_accept(MODE_A, '0);
    collect(0, MODE_A);
    void'(exp_q.pop_front());
    for (int k = 0; k < 3; k++) begin
      check($sformatf("zero_s0_l%0d", lanes_of[k]), res_q[k][63:0], 64'h5555555555555555);
      check($sformatf("zero_s1_l%0d", lanes_of[k]), res_q[k][127:64], 64'h0);
      check($sformatf("zero_s2_l%0d", lanes_of[k]), res_q[k][191:128], 64'h0);
      check($sformatf("zero_lat_l%0d", lanes_of[k]), 64'(lat_q[k]), 64'(N / lanes_of[k] + 1));
    end

    // Unshared value 1 under random masks.
    m1 = {$urandom, $urandom};
    m2 = {$urandom, $urandom};
    do_accept(MODE_A, {m2, m1, 64'h1 ^ m1 ^ m2});
    collect(0, MODE_A);
    for (int k = 0; k < 3; k++)
      check($sformatf("one_xor_l%0d", lanes_of[k]), xor_of(res_q[k]), 64'h555555555555555D);
    check_op("one");

    // Random operations.
    for (int i = 0; i < 12; i++) begin
      m = 1'($urandom_range(0, 1));
      do_accept(m, rand_sh());
      collect(0, m);
      check_op($sformatf("rnd%0d", i));
    end

    // Round trip MAP_A then MAP_B.
    for (int i = 0; i < 3; i++) begin
      v = rand_sh();
      do_accept(MODE_A, v);
      collect(0, MODE_A);
      check_op($sformatf("rtA%0d", i));
      do_accept(MODE_B, res_q[0]);
      collect(0, MODE_B);
      for (int k = 0; k < 3; k++)
        check($sformatf("rt%0d_xor_l%0d", i, lanes_of[k]), xor_of(res_q[k]), xor_of(v));
      check_op($sformatf("rtB%0d", i));
    end

    // Backpressure then back-to-back accept.
    @(negedge clk);
    out_ready = 1'b0;
    m = 1'($urandom_range(0, 1));
    v = rand_sh();
    do_accept(m, v);
    e = model(v, m);
    collect(0, m);
    check_op("bp");
    repeat (10) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("bp_hold_l%0d", lanes_of[k]), xor_of(out_shares_w[k]) ^ out_shares_w[k][63:0],
              xor_of(e) ^ e[63:0]);
        check($sformatf("bp_valid_l%0d", lanes_of[k]), 64'(out_valid_w[k]), 64'd1);
        check($sformatf("bp_in_ready_l%0d", lanes_of[k]), 64'(in_ready_w[k]), 64'd0);
      end
    end
    out_ready = 1'b1;
    m = 1'($urandom_range(0, 1));
    do_accept(m, rand_sh());
    collect(0, m);
    for (int k = 0; k < 3; k++)
      check($sformatf("b2b_run_l%0d", lanes_of[k]), 64'(st1_q[k]), 64'(ST_RUN));
    check_op("b2b");

    // Reset during RUN cycle 5.
    do_accept(MODE_A, rand_sh());
    void'(exp_q.pop_front());
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("rstrun_state", 64'(dbg_w[0]), 64'(ST_RUN));
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("rstrun_in_ready_l%0d", lanes_of[k]), 64'(in_ready_w[k]), 64'd0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rstrun_idle_l%0d", lanes_of[k]), 64'(dbg_w[k]), 64'(ST_IDLE));
      for (int s = 0; s < S; s++)
        check($sformatf("rstrun_zero_l%0d_s%0d", lanes_of[k], s), out_shares_w[k][s*W +: W], 64'h0);
    end
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (out_valid_w[k]) seen++;
    end
    check("rstrun_no_out", 64'(seen), 64'd0);

    // Mode and data changes during RUN are ignored.
    @(negedge clk);
    out_ready = 1'b0;
    m = 1'($urandom_range(0, 1));
    do_accept(m, rand_sh());
    collect(1, m);
    check_op("hold_mode");
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
